wb_master_bridge: RTL and testbench

WB_MASTER_BRIDGE -- requirements
Module: wb_master_bridge

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_timeout.sv | 39 +++
 rtl/wb_master_bridge.sv | 156 +++++++++++++++
 tb/tb_wb_master_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone master family: FSM encoding and the
// default bus timeout used when an instantiation does not override it.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    localparam int unsigned WB_DEFAULT_TIMEOUT = 255;
    localparam int unsigned WB_DATA_WIDTH      = 32;

endpackage

// File: rtl/wb_timeout.sv
// Bus-cycle watchdog: counts enabled cycles since the last clear and flags the
// cycle that would bring the count up to TIMEOUT.
module wb_timeout #(
    parameter int unsigned TIMEOUT = wb_pkg::WB_DEFAULT_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q, count_d;

    // count_q holds the number of enabled cycles already completed, so the
    // TIMEOUT-th enabled cycle is the one that sees LAST.
    assign o_expired = i_enable && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_enable && !o_expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding command/response to Wishbone pipelined master bridge with
// stall handling, error capture and a bus-cycle timeout.
module wb_master_bridge
    import wb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned TIMEOUT    = WB_DEFAULT_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]           i_cmd_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_err,
    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_data,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_err,
    input  logic [31:0]           i_wb_data
);

    wb_state_e state_q, state_d;

    logic                  cyc_q, cyc_d;
    logic                  stb_q, stb_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rspData_q, rspData_d;
    logic                  rspErr_q, rspErr_d;

    logic tmoClear, tmoEnable, tmoExpired;
    logic busDone, tmoDone;

    assign tmoClear  = (state_q == ST_IDLE);
    assign tmoEnable = (state_q == ST_REQ) || (state_q == ST_WAIT);

    wb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (tmoClear),
        .i_enable  (tmoEnable),
        .o_expired (tmoExpired)
    );

    // A slave reply only counts once the request has been accepted (stall low
    // in REQ, or any cycle of WAIT); a reply in the final timeout cycle wins.
    always_comb begin
        state_d   = state_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rspData_d = rspData_q;
        rspErr_d  = rspErr_q;
        busDone   = 1'b0;
        tmoDone   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid) begin
                    we_d    = i_cmd_we;
                    addr_d  = i_cmd_addr;
                    wdata_d = i_cmd_data;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (!i_wb_stall && (i_wb_ack || i_wb_err)) begin
                    busDone = 1'b1;
                end else if (tmoExpired) begin
                    tmoDone = 1'b1;
                end else if (!i_wb_stall) begin
                    stb_d   = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_wb_ack || i_wb_err) begin
                    busDone = 1'b1;
                end else if (tmoExpired) begin
                    tmoDone = 1'b1;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (busDone) begin
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            rspErr_d  = i_wb_err;
            rspData_d = (i_wb_err || we_q) ? 32'h0 : i_wb_data;
            state_d   = ST_RESP;
        end else if (tmoDone) begin
            cyc_d     = 1'b0;
            stb_d     = 1'b0;
            rspErr_d  = 1'b1;
            rspData_d = 32'h0;
            state_d   = ST_RESP;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            rspData_q <= 32'h0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rspData_q <= rspData_d;
            rspErr_q  <= rspErr_d;
        end
    end

    assign o_cmd_ready = (state_q == ST_IDLE);
    assign o_rsp_valid = (state_q == ST_RESP);
    assign o_rsp_data  = rspData_q;
    assign o_rsp_err   = rspErr_q;
    assign o_wb_cyc    = cyc_q;
    assign o_wb_stb    = stb_q;
    assign o_wb_we     = we_q;
    assign o_wb_addr   = addr_q;
    assign o_wb_data   = wdata_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized bench for wb_master_bridge: each transaction is expanded into a
// cycle timeline from its stall/ack parameters and checked every cycle.
module tb_wb_master_bridge;

    localparam int AW  = 30;
    localparam int TMO = 255;

    logic          clk = 1'b0;
    logic          rstN;
    logic          cmdValid, cmdWe;
    logic [AW-1:0] cmdAddr;
    logic [31:0]   cmdData;
    logic          rspReady;
    logic          wbStall, wbAck, wbErr;
    logic [31:0]   wbDataIn;

    logic          oCmdReady, oRspValid, oRspErr;
    logic [31:0]   oRspData;
    logic          oWbCyc, oWbStb, oWbWe;
    logic [AW-1:0] oWbAddr;
    logic [31:0]   oWbData;

    always #5 clk = ~clk;

    wb_master_bridge #(
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_cmd_valid (cmdValid),
        .o_cmd_ready (oCmdReady),
        .i_cmd_we    (cmdWe),
        .i_cmd_addr  (cmdAddr),
        .i_cmd_data  (cmdData),
        .o_rsp_valid (oRspValid),
        .i_rsp_ready (rspReady),
        .o_rsp_data  (oRspData),
        .o_rsp_err   (oRspErr),
        .o_wb_cyc    (oWbCyc),
        .o_wb_stb    (oWbStb),
        .o_wb_we     (oWbWe),
        .o_wb_addr   (oWbAddr),
        .o_wb_data   (oWbData),
        .i_wb_stall  (wbStall),
        .i_wb_ack    (wbAck),
        .i_wb_err    (wbErr),
        .i_wb_data   (wbDataIn)
    );

    int testsRun    = 0;
    int testsFailed = 0;

    // Per-cycle expectations written by the stimulus, consumed at negedge
    bit            chkEn = 1'b0;
    logic          eCmdReady = 1'b1, eCyc = 1'b0, eStb = 1'b0, eRspValid = 1'b0;
    logic          eRspErr = 1'b0, eWe = 1'b0;
    logic [AW-1:0] eAddr = '0;
    logic [31:0]   eWbData = 32'h0, eRspData = 32'h0;

    int          stbCnt = 0, cycCnt = 0, rspCnt = 0, hsCnt = 0;
    logic [31:0] lastRspData = 32'h0;
    logic        lastRspErr = 1'b0;

    int s0, c0, r0, h0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("cmd_ready", 32'(oCmdReady), 32'(eCmdReady));
            checkOutput("wb_cyc", 32'(oWbCyc), 32'(eCyc));
            checkOutput("wb_stb", 32'(oWbStb), 32'(eStb));
            checkOutput("rsp_valid", 32'(oRspValid), 32'(eRspValid));
            if (eCyc) begin
                checkOutput("wb_addr", 32'(oWbAddr), 32'(eAddr));
                checkOutput("wb_we", 32'(oWbWe), 32'(eWe));
                checkOutput("wb_data", oWbData, eWbData);
            end
            if (eRspValid) begin
                checkOutput("rsp_err", 32'(oRspErr), 32'(eRspErr));
                checkOutput("rsp_data", oRspData, eRspData);
            end
        end
    end

    always @(negedge clk) begin
        if (oWbStb) stbCnt++;
        if (oWbCyc) cycCnt++;
        if (oRspValid) rspCnt++;
        if (oRspValid && rspReady) begin
            hsCnt++;
            lastRspData = oRspData;
            lastRspErr  = oRspErr;
        end
    end

    task automatic setIdleExp();
        eCmdReady = 1'b1;
        eCyc      = 1'b0;
        eStb      = 1'b0;
        eRspValid = 1'b0;
    endtask

    task automatic randomCmd();
        cmdWe   = 1'($urandom_range(0, 1));
        cmdAddr = AW'($urandom);
        cmdData = $urandom;
    endtask

    task automatic snap();
        s0 = stbCnt;
        c0 = cycCnt;
        r0 = rspCnt;
        h0 = hsCnt;
    endtask

    task automatic idleCycles(input int n, input logic strayAck);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cmdValid = 1'b0;
            randomCmd();
            wbAck    = strayAck;
            wbErr    = 1'b0;
            wbStall  = 1'($urandom_range(0, 1));
            wbDataIn = $urandom;
            rspReady = 1'($urandom_range(0, 1));
            setIdleExp();
        end
    endtask

    // kind: 0 = ack, 1 = err, 2 = ack+err. delay counts cycles after acceptance.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [31:0] data, input logic [31:0] rdata,
                                 input int stalls, input int delay, input int kind,
                                 input int holdOff, input int gap);
        int n, nc, stbLen;
        logic expErr;
        logic [31:0] expData;
        n       = stalls + 1 + delay;
        nc      = (n > TMO) ? TMO : n;
        stbLen  = (stalls + 1 < nc) ? stalls + 1 : nc;
        expErr  = (n > TMO) || (kind != 0);
        expData = (expErr || we) ? 32'h0 : rdata;

        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            cmdValid = 1'b0;
            randomCmd();
            wbAck    = 1'($urandom_range(0, 1));
            wbErr    = ($urandom_range(0, 3) == 0);
            wbStall  = 1'($urandom_range(0, 1));
            wbDataIn = $urandom;
            rspReady = 1'($urandom_range(0, 1));
            setIdleExp();
        end

        @(posedge clk); #1;
        cmdValid = 1'b1;
        cmdWe    = we;
        cmdAddr  = addr;
        cmdData  = data;
        wbAck    = 1'($urandom_range(0, 1));
        wbErr    = ($urandom_range(0, 3) == 0);
        wbStall  = 1'($urandom_range(0, 1));
        wbDataIn = $urandom;
        rspReady = 1'($urandom_range(0, 1));
        setIdleExp();

        for (int t = 1; t <= nc; t++) begin
            @(posedge clk); #1;
            cmdValid = 1'($urandom_range(0, 1));
            randomCmd();
            wbStall  = (t <= stalls) ? 1'b1 :
                       (t == stalls + 1) ? 1'b0 : 1'($urandom_range(0, 1));
            wbDataIn = $urandom;
            if (t == n) begin
                wbAck    = (kind != 1);
                wbErr    = (kind != 0);
                wbDataIn = rdata;
            end else if (t <= stalls) begin
                wbAck = 1'($urandom_range(0, 1));
                wbErr = ($urandom_range(0, 3) == 0);
            end else begin
                wbAck = 1'b0;
                wbErr = 1'b0;
            end
            rspReady  = 1'($urandom_range(0, 1));
            eCmdReady = 1'b0;
            eCyc      = 1'b1;
            eStb      = (t <= stbLen);
            eRspValid = 1'b0;
            eAddr     = addr;
            eWe       = we;
            eWbData   = data;
        end

        for (int r = 0; r <= holdOff; r++) begin
            @(posedge clk); #1;
            cmdValid  = 1'($urandom_range(0, 1));
            randomCmd();
            wbAck     = 1'($urandom_range(0, 1));
            wbErr     = ($urandom_range(0, 3) == 0);
            wbStall   = 1'($urandom_range(0, 1));
            wbDataIn  = $urandom;
            rspReady  = (r == holdOff);
            eCmdReady = 1'b0;
            eCyc      = 1'b0;
            eStb      = 1'b0;
            eRspValid = 1'b1;
            eRspErr   = expErr;
            eRspData  = expData;
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        int kind;
        rstN     = 1'b1;
        cmdValid = 1'b0;
        cmdWe    = 1'b0;
        cmdAddr  = '0;
        cmdData  = 32'h0;
        rspReady = 1'b0;
        wbStall  = 1'b0;
        wbAck    = 1'b0;
        wbErr    = 1'b0;
        wbDataIn = 32'h0;

        #2 rstN = 1'b0;
        #2;
        checkOutput("rst_cmd_ready", 32'(oCmdReady), 32'd1);
        checkOutput("rst_cyc", 32'(oWbCyc), 32'd0);
        checkOutput("rst_stb", 32'(oWbStb), 32'd0);
        checkOutput("rst_we", 32'(oWbWe), 32'd0);
        checkOutput("rst_addr", 32'(oWbAddr), 32'd0);
        checkOutput("rst_wdata", oWbData, 32'd0);
        checkOutput("rst_rsp_valid", 32'(oRspValid), 32'd0);
        checkOutput("rst_rsp_err", 32'(oRspErr), 32'd0);
        checkOutput("rst_rsp_data", oRspData, 32'd0);
        setIdleExp();
        chkEn = 1'b1;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;

        // Write, no stall, ack one cycle after acceptance
        snap();
        applyStimulus(1'b1, '0, 32'h1, 32'hDEAD_BEEF, 0, 1, 0, 0, 1);
        idleCycles(1, 1'b0);
        checkOutput("wr_stb_cycles", 32'(stbCnt - s0), 32'd1);
        checkOutput("wr_cyc_cycles", 32'(cycCnt - c0), 32'd2);
        checkOutput("wr_rsp_err", 32'(lastRspErr), 32'd0);
        checkOutput("wr_rsp_data", lastRspData, 32'd0);

        // Minimum latency read: ack in the acceptance cycle
        snap();
        applyStimulus(1'b0, 30'h155, 32'h0, 32'h1234_5678, 0, 0, 0, 0, 0);
        idleCycles(1, 1'b0);
        checkOutput("min_cyc_cycles", 32'(cycCnt - c0), 32'd1);
        checkOutput("min_rsp_data", lastRspData, 32'h1234_5678);

        // Read with four stall cycles
        snap();
        applyStimulus(1'b0, 30'h0ABC, 32'h0, 32'h0000_0005, 4, 0, 0, 0, 0);
        idleCycles(1, 1'b0);
        checkOutput("stall_stb_cycles", 32'(stbCnt - s0), 32'd5);
        checkOutput("stall_rsp_data", lastRspData, 32'h5);
        checkOutput("stall_rsp_err", 32'(lastRspErr), 32'd0);

        // Slave never answers
        snap();
        applyStimulus(1'b0, 30'h3, 32'h0, 32'hFFFF_FFFF, 0, 400, 0, 0, 0);
        idleCycles(1, 1'b0);
        checkOutput("tmo_cyc_cycles", 32'(cycCnt - c0), 32'd255);
        checkOutput("tmo_stb_cycles", 32'(stbCnt - s0), 32'd1);
        checkOutput("tmo_rsp_err", 32'(lastRspErr), 32'd1);
        checkOutput("tmo_rsp_data", lastRspData, 32'd0);

        // Slave stalls forever: stb and cyc drop together
        snap();
        applyStimulus(1'b1, 30'h7, 32'h55, 32'h0, 400, 0, 0, 0, 0);
        idleCycles(1, 1'b0);
        checkOutput("tmo_stall_stb_cycles", 32'(stbCnt - s0), 32'd255);
        checkOutput("tmo_stall_cyc_cycles", 32'(cycCnt - c0), 32'd255);

        // ack and err together in WAIT, then stray acks while idle
        snap();
        applyStimulus(1'b0, 30'h9, 32'h0, 32'hCAFE_F00D, 0, 2, 2, 0, 0);
        idleCycles(5, 1'b1);
        checkOutput("both_rsp_err", 32'(lastRspErr), 32'd1);
        checkOutput("both_rsp_data", lastRspData, 32'd0);
        checkOutput("stray_rsp_cycles", 32'(rspCnt - r0), 32'd1);

        // Response back-pressure for ten cycles
        snap();
        applyStimulus(1'b0, 30'h11, 32'h0, 32'hA5A5_0023, 0, 0, 0, 10, 0);
        @(posedge clk); #1;
        checkOutput("b2b_cmd_ready", 32'(oCmdReady), 32'd1);
        cmdValid = 1'b0;
        setIdleExp();
        checkOutput("hold_rsp_cycles", 32'(rspCnt - r0), 32'd11);
        checkOutput("hold_rsp_data", lastRspData, 32'hA5A5_0023);

        // Reset during WAIT abandons the cycle
        idleCycles(1, 1'b0);
        a = 30'h2A;
        @(posedge clk); #1;
        cmdValid = 1'b1; cmdWe = 1'b0; cmdAddr = a;
        wbStall = 1'b0; wbAck = 1'b0; wbErr = 1'b0; rspReady = 1'b0;
        setIdleExp();
        @(posedge clk); #1;
        cmdValid = 1'b0;
        eCmdReady = 1'b0; eCyc = 1'b1; eStb = 1'b1; eRspValid = 1'b0;
        eAddr = a; eWe = 1'b0; eWbData = oWbData;
        @(posedge clk); #1;
        eStb = 1'b0;
        @(negedge clk); #1;
        chkEn = 1'b0;
        snap();
        rstN = 1'b0;
        wbAck = 1'b1;
        #1;
        checkOutput("rstw_cyc", 32'(oWbCyc), 32'd0);
        checkOutput("rstw_stb", 32'(oWbStb), 32'd0);
        checkOutput("rstw_rsp_valid", 32'(oRspValid), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        setIdleExp();
        chkEn = 1'b1;
        @(posedge clk); #1;
        checkOutput("rstw_cmd_ready", 32'(oCmdReady), 32'd1);
        idleCycles(3, 1'b1);
        idleCycles(1, 1'b0);
        checkOutput("rstw_no_rsp", 32'(rspCnt - r0), 32'd0);
        checkOutput("rstw_no_hs", 32'(hsCnt - h0), 32'd0);

        for (int i = 0; i < 60; i++) begin
            kind = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 2));
            applyStimulus(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom,
                          ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 5)), kind,
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end
        idleCycles(2, 1'b0);
        chkEn = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
